memoria_ctrl: RTL

MEMORIA_CTRL -- requirements
Module: memoria_ctrl

---
 rtl/memoria_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/memoria_ctrl.sv
// rtl/memoria_ctrl.sv - single-port memory command controller: read, write, fill and illegal-op responses
module memoria_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [ADDR_W-1:0] req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_s,
  input  logic [DATA_W-1:0] mem_out,
  output logic              busy
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    FILL,
    RESP
  } state_t;

  state_t            state, state_d;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_READ, OP_WRITE: state_d = ACCESS;
            OP_FILL:           state_d = FILL;
            default:           state_d = RESP;
          endcase
        end
      end
      ACCESS:  state_d = (op_q == OP_WRITE) ? RESP : CAPTURE;
      CAPTURE: state_d = RESP;
      FILL:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // cnt_q counts remaining fill writes after the current one; addr_q doubles as the fill pointer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q       <= req_op;
            addr_q     <= req_addr;
            data_q     <= req_data;
            cnt_q      <= req_len;
            rsp_data_q <= '0;
            rsp_err_q  <= (req_op == 2'b11);
          end
        end
        ACCESS: begin
          if (op_q == OP_WRITE) rsp_data_q <= data_q;
        end
        CAPTURE: rsp_data_q <= mem_out;
        FILL: begin
          if (cnt_q == '0) begin
            rsp_data_q <= data_q;
          end else begin
            cnt_q  <= cnt_q - 1'b1;
            addr_q <= addr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = addr_q;
  assign mem_in    = data_q;
  assign mem_s     = (state == FILL) || ((state == ACCESS) && (op_q == OP_WRITE));

endmodule
